// File: rtl/andor_pkg.sv
// Shared constants and helpers for the stages of the and/or chain.
package andor_pkg;

   localparam int DEF_WIDTH      = 8;
   localparam int DEF_DROP_CNT_W = 8;

   // Width of a bit-position counter for a word of the given size.
   function automatic int fill_w(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/andor_deser_sat_counter.sv
// Saturating up-counter with synchronous clear, used for the dropped-word count.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc)
         count <= sat_inc(count);
   end

endmodule

// File: rtl/andor_deser.sv
// Packs the serial and/or stage output LSB-first into words behind a
// single-entry valid/ready output register; words that cannot be held are dropped.
module andor_deser
   import andor_pkg::*;
#(
   parameter  int WIDTH      = DEF_WIDTH,
   parameter  int DROP_CNT_W = DEF_DROP_CNT_W,
   localparam int FILL_W     = fill_w(WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  bit_in,
   input  logic                  bit_valid,
   input  logic                  flush,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [FILL_W-1:0]     fill,
   output logic                  overflow,
   output logic [DROP_CNT_W-1:0] drop_count
);

   // Only WIDTH-1 bits are stored: the final bit goes straight into the word.
   logic [WIDTH-2:0] shift;
   logic             accept;
   logic             last;
   logic             can_load;
   logic             drop;
   logic [WIDTH-1:0] word;

   assign accept   = bit_valid & ~flush;
   assign last     = accept && (fill == FILL_W'(WIDTH - 1));
   assign can_load = ~out_valid | out_ready;
   assign drop     = last & ~can_load;
   assign word     = {bit_in, shift};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift     <= '0;
         fill      <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if (flush) begin
            shift    <= '0;
            fill     <= '0;
            overflow <= 1'b0;
         end else if (bit_valid) begin
            // Explicit wrap keeps non-power-of-two widths correct.
            if (last)
               fill <= '0;
            else
               fill <= fill + 1'b1;
            for (int i = 0; i < WIDTH - 1; i++)
               if (fill == FILL_W'(i))
                  shift[i] <= bit_in;
            if (drop)
               overflow <= 1'b1;
         end

         // Flush never touches the output register.
         if (last && can_load) begin
            out_data  <= word;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   sat_counter #(
      .W(DROP_CNT_W)
   ) u_drop_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (drop),
      .clr  (flush),
      .count(drop_count)
   );

endmodule

// File: tb/tb_andor_deser.sv
// Directed bench for andor_deser; a second instance with a 2-bit drop counter
// shares the stimulus to exercise saturation.
module tb_andor_deser;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       bit_in = 1'b0;
   logic       bit_valid = 1'b0;
   logic       flush = 1'b0;
   logic       out_ready = 1'b0;

   logic [7:0] out_data,   out_data2;
   logic       out_valid,  out_valid2;
   logic [2:0] fill,       fill2;
   logic       overflow,   overflow2;
   logic [7:0] drop_count;
   logic [1:0] drop_count2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   andor_deser #(.WIDTH(8), .DROP_CNT_W(8)) dut (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .flush(flush),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .fill(fill), .overflow(overflow), .drop_count(drop_count)
   );

   andor_deser #(.WIDTH(8), .DROP_CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .flush(flush),
      .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready),
      .fill(fill2), .overflow(overflow2), .drop_count(drop_count2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      bit_valid = 1'b1;
      bit_in    = b;
      tick();
      bit_valid = 1'b0;
      bit_in    = 1'b0;
   endtask

   task automatic send_bits(input logic [7:0] w, input int lo, input int hi);
      for (int i = lo; i <= hi; i++)
         send_bit(w[i]);
   endtask

   initial begin
      // Reset is already asserted at time zero: outputs must be clear.
      #2;
      chk("rst_data",  out_data,   32'h0);
      chk("rst_valid", out_valid,  32'h0);
      chk("rst_fill",  fill,       32'h0);
      chk("rst_ovf",   overflow,   32'h0);
      chk("rst_drop",  drop_count, 32'h0);
      tick();
      rst = 1'b0;

      // Basic pack, consumer always ready.
      out_ready = 1'b1;
      send_bits(8'h4D, 0, 7);
      chk("pack_valid", out_valid, 32'h1);
      chk("pack_data",  out_data,  32'h4D);
      chk("pack_fill",  fill,      32'h0);
      tick();
      chk("pack_one_cycle", out_valid, 32'h0);
      chk("pack_data_hold", out_data,  32'h4D);

      // Gapped input.
      send_bits(8'h4D, 0, 3);
      chk("gap_fill_a", fill, 32'h4);
      repeat (3) tick();
      chk("gap_fill_b",  fill,      32'h4);
      chk("gap_novalid", out_valid, 32'h0);
      send_bits(8'h4D, 4, 7);
      chk("gap_valid", out_valid, 32'h1);
      chk("gap_data",  out_data,  32'h4D);
      tick();

      // Backpressure and drop.
      out_ready = 1'b0;
      send_bits(8'hFF, 0, 7);
      chk("bp_valid", out_valid, 32'h1);
      chk("bp_data",  out_data,  32'hFF);
      send_bits(8'h00, 0, 7);
      chk("drop_data",  out_data,   32'hFF);
      chk("drop_ovf",   overflow,   32'h1);
      chk("drop_cnt1",  drop_count, 32'h1);
      repeat (4) send_bits(8'h00, 0, 7);
      chk("drop_cnt5",  drop_count,  32'h5);
      chk("drop_sat",   drop_count2, 32'h3);
      chk("drop_hold",  out_valid,   32'h1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_consumed", out_valid, 32'h0);
      chk("bp_data_kept", out_data, 32'hFF);

      // Flush clears status.
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_ovf",   overflow,    32'h0);
      chk("flush_drop",  drop_count,  32'h0);
      chk("flush_drop2", drop_count2, 32'h0);

      // Simultaneous consume and complete.
      send_bits(8'hA5, 0, 7);
      chk("sim_pend", out_data, 32'hA5);
      send_bits(8'h3C, 0, 6);
      out_ready = 1'b1;
      send_bit(1'b0);
      out_ready = 1'b0;
      chk("sim_data",  out_data,  32'h3C);
      chk("sim_valid", out_valid, 32'h1);
      chk("sim_ovf",   overflow,  32'h0);

      // Flush with a pending word and a drop recorded.
      send_bits(8'hFF, 0, 7);
      chk("pre_flush_ovf", overflow, 32'h1);
      send_bits(8'h1F, 0, 4);
      chk("pre_flush_fill", fill, 32'h5);
      flush = 1'b1;
      bit_valid = 1'b1;
      bit_in = 1'b1;
      tick();
      flush = 1'b0;
      bit_valid = 1'b0;
      bit_in = 1'b0;
      chk("fl_fill",  fill,       32'h0);
      chk("fl_ovf",   overflow,   32'h0);
      chk("fl_drop",  drop_count, 32'h0);
      chk("fl_valid", out_valid,  32'h1);
      chk("fl_data",  out_data,   32'h3C);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("fl_consumed", out_valid, 32'h0);
      send_bits(8'h81, 0, 7);
      chk("fl_new_data",  out_data,  32'h81);
      chk("fl_new_valid", out_valid, 32'h1);

      // Asynchronous reset mid-word with a pending word and a drop.
      send_bits(8'h00, 0, 7);
      chk("pre_rst_drop2", drop_count2, 32'h1);
      send_bits(8'h07, 0, 2);
      chk("pre_rst_fill", fill, 32'h3);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_data",  out_data,    32'h0);
      chk("arst_valid", out_valid,   32'h0);
      chk("arst_fill",  fill,        32'h0);
      chk("arst_ovf",   overflow,    32'h0);
      chk("arst_drop",  drop_count,  32'h0);
      chk("arst_drop2", drop_count2, 32'h0);
      #2;
      rst = 1'b0;
      tick();

      // A full fresh word is needed before any output.
      out_ready = 1'b1;
      send_bits(8'h5A, 0, 6);
      chk("post_rst_quiet", out_valid, 32'h0);
      send_bit(1'b0);
      chk("post_rst_valid", out_valid, 32'h1);
      chk("post_rst_data",  out_data,  32'h5A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/andor_deser.md
Name: andor_deser

Overview:
- Downstream consumer of the registered serial bit produced by the and/or macro stage.
- Packs the serial bit stream, LSB-first, into WIDTH-bit words.
- Presents each completed word through a single-entry output register with a valid/ready handshake.
- The serial source cannot stall, so a word that completes while the output register is still occupied is dropped and counted.

Parameters:
- WIDTH, 8: bits per assembled word; legal range 2..32.
- DROP_CNT_W, 8: width of the saturating dropped-word counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- bit_in  input  1  serial data bit (the and/or stage output).
- bit_valid  input  1  bit_in is sampled this cycle.
- flush  input  1  discard the partial word and clear status.
- out_data  output  WIDTH  assembled word; bit 0 is the first bit received.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts the word.
- fill  output  $clog2(WIDTH)  number of bits currently in the partial word.
- overflow  output  1  sticky: at least one word was dropped.
- drop_count  output  DROP_CNT_W  number of dropped words, saturating.

Behaviour:
- Reset, asynchronous on rst=1: out_data=0, out_valid=0, fill=0, overflow=0, drop_count=0, shift register=0.
- All state is registered. There are no combinational paths from inputs to outputs.
- Bit accept, bit_valid=1 and flush=0:
  - shift register bit[fill] <= bit_in.
  - fill increments by 1.
- Word completion: a bit accepted while fill==WIDTH-1 completes the word.
  - fill wraps to 0.
  - The completed word is {bit_in, shift[WIDTH-2:0]}.
- Word delivery:
  - If out_valid=0, or out_valid=1 and out_ready=1 in the same cycle, the completed word loads out_data and out_valid=1 next cycle.
  - Latency: out_valid rises on the cycle after the last bit is sampled.
- Word drop:
  - Condition: word completes while out_valid=1 and out_ready=0.
  - The new word is discarded; out_data is unchanged.
  - overflow <= 1.
  - drop_count increments, saturating at all-ones.
- Handshake:
  - out_valid=1 and out_ready=1 with no completion this cycle → out_valid=0 next cycle.
  - out_data holds its last value; it is not cleared.
  - out_data and out_valid remain stable while out_valid=1 and out_ready=0.
- out_ready while out_valid=0 is ignored.
- Flush, flush=1:
  - fill=0, shift register=0, overflow=0, drop_count=0.
  - Has priority over bit_valid in the same cycle; that bit is discarded.
  - Does NOT affect out_valid or out_data. A pending word survives flush, and a same-cycle out_ready still consumes it.
- bit_valid=0: no state change apart from the output handshake.
- Reset mid-word: the partial word and any pending word are lost. No output activity occurs until WIDTH new bits arrive after rst deasserts.
- fill width: for WIDTH a power of two, fill wraps naturally. Otherwise the wrap at WIDTH-1 is explicit.

Decomposition:
- Shared package andor_pkg:
  - default WIDTH and DROP_CNT_W constants.
  - a clog2-based FILL_W localparam function.
  - shared with other stages of the and/or chain.
- One natural sub-module: sat_counter, parameterised width, with inc and clr inputs; used for drop_count.
- Shift register, fill counter and output register stay in the top module.

Test Plan:
- Basic pack, WIDTH=8, out_ready=1:
  - Stimulus: bits 1,0,1,1,0,0,1,0 on consecutive cycles with bit_valid=1.
  - Required: out_data=8'h4D, out_valid=1 for exactly one cycle, one cycle after the 8th bit; fill returns to 0.
- Gapped input:
  - Stimulus: same bits with bit_valid deasserted for 3 cycles between bits 4 and 5.
  - Required: out_data=8'h4D; fill holds at 4 during the gap.
- Backpressure and drop:
  - Stimulus: out_ready=0; send 8'hFF, then 8'h00.
  - Required: out_data stays 8'hFF, overflow=1, drop_count=1.
  - Then raise out_ready for one cycle: out_valid falls next cycle.
- Simultaneous consume and complete:
  - Stimulus: word 8'hA5 pending; out_ready=1 on the same cycle the last bit of 8'h3C arrives.
  - Required: next cycle out_data=8'h3C, out_valid=1, overflow stays 0.
- Flush:
  - Stimulus: 5 bits sent, flush=1 with bit_valid=1, then 8 bits of 8'h81.
  - Required: fill=0 after flush; out_data=8'h81; overflow and drop_count cleared; a pending word from before the flush stays valid.
- Reset and saturation:
  - Stimulus: DROP_CNT_W=2 with 5 drops.
  - Required: drop_count=3, saturated.
  - Then assert rst asynchronously mid-word: all outputs return to 0 with no clock edge.
